// File: rtl/scg_pkg.sv
// scg_pkg: SDRAM command codes and scheduler state encoding.
// The init states exist only when SCG_INIT_EN is defined.
package scg_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ACT = 4'd1;
  localparam logic [3:0] CMD_READ = 4'd2;
  localparam logic [3:0] CMD_WRITE = 4'd3;
  localparam logic [3:0] CMD_PRE = 4'd4;
  localparam logic [3:0] CMD_REF = 4'd5;
  localparam logic [3:0] CMD_MRS = 4'd6;

  typedef enum logic [3:0] {
`ifdef SCG_INIT_EN
    S_INIT_WAIT,
    S_INIT_PRE,
    S_INIT_RP,
    S_INIT_REF,
    S_INIT_RFC,
    S_INIT_MRS,
    S_INIT_MRD,
`endif
    S_IDLE,
    S_ACT,
    S_RCD_WAIT,
    S_BURST,
    S_RP_WAIT,
    S_REF,
    S_RFC_WAIT
  } state_e;

endpackage

// File: rtl/scg_refresh_timer.sv
// scg_refresh_timer: periodic refresh request generator.
// Terminal counts while a refresh is pending are absorbed.
module scg_refresh_timer #(
  parameter int REF_INTERVAL = 780
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic pending
);

  localparam int CW = $clog2(REF_INTERVAL + 1);
  localparam logic [CW-1:0] RELOAD = CW'(REF_INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic pending_q, pending_d;

  // Count down while enabled; reload and flag a refresh at zero.
  always_comb begin
    cnt_d = cnt_q;
    pending_d = pending_q;
    if (!enable) begin
      cnt_d = RELOAD;
    end else if (cnt_q == '0) begin
      cnt_d = RELOAD;
      pending_d = 1'b1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
    if (clear) pending_d = 1'b0;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= RELOAD;
      pending_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/scg_cmd_sched.sv
// scg_cmd_sched: SDRAM command scheduler (ACT/burst/PRE timing, refresh).
// Optional power-up init sequence enabled by SCG_INIT_EN.
module scg_cmd_sched
  import scg_pkg::*;
#(
  parameter int ROW_W = 12,
  parameter int COL_W = 8,
  parameter int T_RCD = 2,
  parameter int T_RP = 2,
  parameter int T_RFC = 7,
  parameter int REF_INTERVAL = 780,
  parameter int INIT_CYCLES = 20000,
  parameter logic [ROW_W-1:0] MODE_REG = 12'h023
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [2+ROW_W+COL_W-1:0] req_addr,
  output logic                   req_ready,
  output logic                   wr_start,
  output logic                   rd_start,
  input  logic                   wr_done,
  input  logic                   rd_done,
  input  logic [3:0]             wr_cmd,
  input  logic [3:0]             rd_cmd,
  input  logic                   wr_chip,
  input  logic                   rd_chip,
  output logic [3:0]             cmd,
  output logic                   chip,
  output logic [1:0]             sd_ba,
  output logic [ROW_W-1:0]       sd_addr,
  output logic                   init_done
);

  localparam int CNT_W = $clog2(INIT_CYCLES + T_RCD + T_RP + T_RFC + 2);

`ifdef SCG_INIT_EN
  localparam state_e S_RESET = S_INIT_WAIT;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(INIT_CYCLES - 1);
`else
  localparam state_e S_RESET = S_IDLE;
  localparam logic [CNT_W-1:0] CNT_RST = '0;
`endif

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] bank_q, bank_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic wr_q, wr_d;
  logic ref_pending;
  logic sel_done;
  logic cnt_zero;

`ifdef SCG_INIT_EN
  logic init_done_q, init_done_d;
  logic ref2_q, ref2_d;
  assign init_done = init_done_q;
`else
  assign init_done = 1'b1;
`endif

  scg_refresh_timer #(
    .REF_INTERVAL(REF_INTERVAL)
  ) u_ref (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (init_done),
    .clear  (state_q == S_REF),
    .pending(ref_pending)
  );

  assign req_ready = (state_q == S_IDLE) && !ref_pending && init_done;
  assign sel_done = wr_q ? wr_done : rd_done;
  assign cnt_zero = (cnt_q == '0);

  // Next-state, wait-counter load and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bank_d = bank_q;
    row_d = row_q;
    col_d = col_q;
    wr_d = wr_q;
`ifdef SCG_INIT_EN
    init_done_d = init_done_q;
    ref2_d = ref2_q;
`endif
    unique case (state_q)
`ifdef SCG_INIT_EN
      S_INIT_WAIT: begin
        if (cnt_zero) state_d = S_INIT_PRE;
        else cnt_d = cnt_q - 1'b1;
      end
      S_INIT_PRE: begin
        state_d = S_INIT_RP;
        cnt_d = CNT_W'(T_RP - 1);
      end
      S_INIT_RP: begin
        if (cnt_zero) state_d = S_INIT_REF;
        else cnt_d = cnt_q - 1'b1;
      end
      S_INIT_REF: begin
        if (T_RFC > 1) begin
          state_d = S_INIT_RFC;
          cnt_d = CNT_W'(T_RFC - 2);
        end else begin
          state_d = ref2_q ? S_INIT_MRS : S_INIT_REF;
          ref2_d = 1'b1;
        end
      end
      S_INIT_RFC: begin
        if (cnt_zero) begin
          state_d = ref2_q ? S_INIT_MRS : S_INIT_REF;
          ref2_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_INIT_MRS: begin
        state_d = S_INIT_MRD;
        cnt_d = CNT_W'(1);
      end
      S_INIT_MRD: begin
        if (cnt_zero) begin
          state_d = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      S_IDLE: begin
        if (ref_pending) begin
          state_d = S_REF;
        end else if (req_valid && req_ready) begin
          state_d = S_ACT;
          bank_d = req_addr[ROW_W+COL_W +: 2];
          row_d = req_addr[COL_W +: ROW_W];
          col_d = req_addr[COL_W-1:0];
          wr_d = req_write;
        end
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_RCD_WAIT;
          cnt_d = CNT_W'(T_RCD - 2);
        end else begin
          state_d = S_BURST;
        end
      end
      S_RCD_WAIT: begin
        if (cnt_zero) state_d = S_BURST;
        else cnt_d = cnt_q - 1'b1;
      end
      S_BURST: begin
        if (sel_done) begin
          state_d = S_RP_WAIT;
          cnt_d = CNT_W'(T_RP - 1);
        end
      end
      S_RP_WAIT: begin
        if (cnt_zero) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      S_REF: begin
        if (T_RFC > 1) begin
          state_d = S_RFC_WAIT;
          cnt_d = CNT_W'(T_RFC - 2);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RFC_WAIT: begin
        if (cnt_zero) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_RESET;
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_RESET;
      cnt_q <= CNT_RST;
      bank_q <= '0;
      row_q <= '0;
      col_q <= '0;
      wr_q <= 1'b0;
`ifdef SCG_INIT_EN
      init_done_q <= 1'b0;
      ref2_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bank_q <= bank_d;
      row_q <= row_d;
      col_q <= col_d;
      wr_q <= wr_d;
`ifdef SCG_INIT_EN
      init_done_q <= init_done_d;
      ref2_q <= ref2_d;
`endif
    end
  end

  // Command bus decode from registered state and latched request.
  always_comb begin
    cmd = CMD_NOP;
    chip = 1'b0;
    sd_ba = '0;
    sd_addr = '0;
    wr_start = 1'b0;
    rd_start = 1'b0;
    unique case (state_q)
`ifdef SCG_INIT_EN
      S_INIT_PRE: begin
        cmd = CMD_PRE;
        sd_addr[10] = 1'b1;
      end
      S_INIT_REF: cmd = CMD_REF;
      S_INIT_MRS: begin
        cmd = CMD_MRS;
        sd_addr = MODE_REG;
      end
`endif
      S_ACT: begin
        cmd = CMD_ACT;
        sd_ba = bank_q;
        sd_addr = row_q;
      end
      S_BURST: begin
        wr_start = wr_q;
        rd_start = !wr_q;
        cmd = wr_q ? wr_cmd : rd_cmd;
        chip = wr_q ? wr_chip : rd_chip;
        sd_ba = bank_q;
        sd_addr[COL_W-1:0] = col_q;
        sd_addr[10] = 1'b1;
      end
      S_REF: cmd = CMD_REF;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_scg_cmd_sched.sv
// tb_scg_cmd_sched: directed bench for scg_cmd_sched.
// Covers burst sequencing, refresh period/priority, reset abort and init.
module tb_scg_cmd_sched;
  import scg_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_write = 1'b0;
  logic [21:0] req_addr = '0;
  logic req_ready;
  logic wr_start, rd_start;
  logic wr_done = 1'b0;
  logic rd_done = 1'b0;
  logic [3:0] wr_cmd = 4'd0;
  logic [3:0] rd_cmd = 4'd0;
  logic wr_chip = 1'b0;
  logic rd_chip = 1'b0;
  logic [3:0] cmd;
  logic chip;
  logic [1:0] sd_ba;
  logic [11:0] sd_addr;
  logic init_done;

  int nchk = 0;
  int nfail = 0;
  int nwait;
  logic [3:0] exp_c;

  always #5 clk = ~clk;

  scg_cmd_sched #(
    .ROW_W(12), .COL_W(8), .T_RCD(2), .T_RP(2), .T_RFC(7),
    .REF_INTERVAL(20), .INIT_CYCLES(5), .MODE_REG(12'h023)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_ready(req_ready),
    .wr_start(wr_start), .rd_start(rd_start),
    .wr_done(wr_done), .rd_done(rd_done),
    .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
    .wr_chip(wr_chip), .rd_chip(rd_chip),
    .cmd(cmd), .chip(chip), .sd_ba(sd_ba),
    .sd_addr(sd_addr), .init_done(init_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cmd(input logic [3:0] c, input int lim,
                          output int n);
    n = 0;
    while (cmd !== c && n < lim) begin
      step();
      n++;
    end
    chk("wait_cmd_seen", 32'(cmd === c), 32'd1);
  endtask

  initial begin
    step();
    step();
    chk("rst_cmd", 32'(cmd), 32'(CMD_NOP));
    chk("rst_chip", 32'(chip), 32'd0);
    chk("rst_wr_start", 32'(wr_start), 32'd0);
    chk("rst_rd_start", 32'(rd_start), 32'd0);
    chk("rst_addr", 32'(sd_addr), 32'd0);
    chk("rst_ba", 32'(sd_ba), 32'd0);
`ifdef SCG_INIT_EN
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
`else
    chk("rst_init_done", 32'(init_done), 32'd1);
    chk("rst_ready", 32'(req_ready), 32'd1);
`endif
    n_rst = 1'b1;

`ifdef SCG_INIT_EN
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = {2'd3, 12'h0AA, 8'h01};
    for (int i = 1; i <= 26; i++) begin
      if (i == 6) exp_c = CMD_PRE;
      else if (i == 9 || i == 16) exp_c = CMD_REF;
      else if (i == 23) exp_c = CMD_MRS;
      else exp_c = CMD_NOP;
      chk($sformatf("init_cmd_%0d", i), 32'(cmd), 32'(exp_c));
      chk($sformatf("init_done_%0d", i), 32'(init_done), 32'(i == 26));
      chk($sformatf("init_ready_%0d", i), 32'(req_ready), 32'(i == 26));
      if (i == 6) chk("init_pre_a10", 32'(sd_addr[10]), 32'd1);
      if (i == 23) chk("init_mrs_addr", 32'(sd_addr), 32'h023);
      step();
    end
    req_valid = 1'b0;
    chk("init_act", 32'(cmd), 32'(CMD_ACT));
    chk("init_act_addr", 32'(sd_addr), 32'h0AA);
    step();
    step();
    chk("init_rd_start", 32'(rd_start), 32'd1);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
`endif

    // refresh period with no traffic
    wait_cmd(CMD_REF, 60, nwait);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) chk("rfc_nop", 32'(cmd), 32'(CMD_NOP));
      if (i == 18) chk("ready_before_pend", 32'(req_ready), 32'd1);
      if (i == 19) chk("ready_pend", 32'(req_ready), 32'd0);
    end
    chk("ref_period", 32'(cmd), 32'(CMD_REF));

    // write: request held through RFC_WAIT, accepted on IDLE
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = {2'd1, 12'h055, 8'h10};
    wr_cmd = CMD_WRITE;
    wr_chip = 1'b1;
    repeat (6) step();
    chk("rfc_ready", 32'(req_ready), 32'd0);
    step();
    chk("idle_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("wr_act_cmd", 32'(cmd), 32'(CMD_ACT));
    chk("wr_act_ba", 32'(sd_ba), 32'd1);
    chk("wr_act_addr", 32'(sd_addr), 32'h055);
    step();
    chk("wr_rcd_cmd", 32'(cmd), 32'(CMD_NOP));
    chk("wr_rcd_start", 32'(wr_start), 32'd0);
    step();
    chk("wr_start", 32'(wr_start), 32'd1);
    chk("wr_rd_start", 32'(rd_start), 32'd0);
    chk("wr_col_addr", 32'(sd_addr), 32'h410);
    chk("wr_burst_ba", 32'(sd_ba), 32'd1);
    chk("wr_cmd_pass", 32'(cmd), 32'(CMD_WRITE));
    chk("wr_chip_pass", 32'(chip), 32'd1);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("ignore_rd_done", 32'(wr_start), 32'd1);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("wr_start_drop", 32'(wr_start), 32'd0);
    chk("wr_rp_cmd", 32'(cmd), 32'(CMD_NOP));
    chk("wr_rp_chip", 32'(chip), 32'd0);
    step();
    chk("wr_rp2_ready", 32'(req_ready), 32'd0);
    step();
    chk("wr_after_rp_ready", 32'(req_ready), 32'd1);

    // read with pass-through of the read FSM
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = {2'd2, 12'h3AB, 8'hFF};
    rd_cmd = CMD_READ;
    rd_chip = 1'b1;
    wr_chip = 1'b0;
    step();
    req_valid = 1'b0;
    chk("rd_act_cmd", 32'(cmd), 32'(CMD_ACT));
    chk("rd_act_ba", 32'(sd_ba), 32'd2);
    chk("rd_act_addr", 32'(sd_addr), 32'h3AB);
    step();
    step();
    chk("rd_cmd_pass", 32'(cmd), 32'(CMD_READ));
    chk("rd_chip_pass", 32'(chip), 32'd1);
    chk("rd_start", 32'(rd_start), 32'd1);
    chk("rd_wr_start", 32'(wr_start), 32'd0);
    chk("rd_col_addr", 32'(sd_addr), 32'h4FF);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("ignore_wr_done", 32'(rd_start), 32'd1);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;

    // refresh pending meets a request in IDLE
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = {2'd0, 12'h123, 8'h05};
    step();
    step();
    chk("collide_ready", 32'(req_ready), 32'd0);
    chk("collide_no_act", 32'(cmd), 32'(CMD_NOP));
    step();
    chk("collide_ref_first", 32'(cmd), 32'(CMD_REF));
    repeat (7) step();
    chk("collide_rfc_end_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("collide_act", 32'(cmd), 32'(CMD_ACT));
    chk("collide_act_addr", 32'(sd_addr), 32'h123);
    step();
    step();
    chk("abort_burst_start", 32'(wr_start), 32'd1);

    // reset asserted mid-burst
    n_rst = 1'b0;
    #1;
    chk("abort_wr_start", 32'(wr_start), 32'd0);
    chk("abort_cmd", 32'(cmd), 32'(CMD_NOP));
    chk("abort_addr", 32'(sd_addr), 32'd0);
    step();
    n_rst = 1'b1;
    step();
`ifdef SCG_INIT_EN
    chk("post_rst_ready", 32'(req_ready), 32'd0);
`else
    chk("post_rst_ready", 32'(req_ready), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
